// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU op encodings, operand-1
// selects, the decoded bundle layout and immediate extraction helpers.
package rv32i_pkg;

   // Major opcodes (inst[6:0])
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] JAL    = 7'b1101111;

   // ALU major op select
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SLT = 3'b001;
   localparam logic [2:0] ALU_SLL = 3'b010;
   localparam logic [2:0] ALU_SRL = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_OR  = 3'b101;
   localparam logic [2:0] ALU_AND = 3'b110;

   // Operand-1 select
   localparam logic [1:0] OP1_RS1  = 2'b00;
   localparam logic [1:0] OP1_PC   = 2'b01;
   localparam logic [1:0] OP1_ZERO = 2'b10;

   // Decoded bundle carried by the pipeline register
   typedef struct packed {
      logic [2:0]  opsel;
      logic        sub;
      logic        uns;
      logic        arith;
      logic [1:0]  op1sel;
      logic        op2imm;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rd_wen;
      logic        illegal;
   } dec_bundle_t;

   localparam int DEC_W = $bits(dec_bundle_t);

   // Immediate formats, all sign-extended from inst[31]
   function automatic logic [31:0] imm_i(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[31:25], inst[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] inst);
      return {inst[31:12], 12'h000};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] inst);
      return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/inst_decode.sv
// Purely combinational RV32I decoder: instruction word to packed decode bundle.
module inst_decode
   import rv32i_pkg::*;
(
   input  logic [31:0]      i_inst,
   output logic [DEC_W-1:0] o_bundle
);

   logic [6:0]  opcode_s;
   logic [2:0]  funct3_s;
   logic [6:0]  funct7_s;
   logic [2:0]  f3_opsel_s;
   logic        f3_uns_s;
   logic        illegal_s;
   logic        wen_s;
   dec_bundle_t dec_s;

   assign opcode_s = i_inst[6:0];
   assign funct3_s = i_inst[14:12];
   assign funct7_s = i_inst[31:25];

   // ALU op shared by OP and OP-IMM, selected by funct3
   always_comb begin
      f3_opsel_s = ALU_ADD;
      f3_uns_s   = 1'b0;
      case (funct3_s)
         3'b000:  f3_opsel_s = ALU_ADD;
         3'b001:  f3_opsel_s = ALU_SLL;
         3'b010:  f3_opsel_s = ALU_SLT;
         3'b011: begin
            f3_opsel_s = ALU_SLT;
            f3_uns_s   = 1'b1;
         end
         3'b100:  f3_opsel_s = ALU_XOR;
         3'b101:  f3_opsel_s = ALU_SRL;
         3'b110:  f3_opsel_s = ALU_OR;
         3'b111:  f3_opsel_s = ALU_AND;
         default: f3_opsel_s = ALU_ADD;
      endcase
   end

   // Opcode decode, legality check and illegal-instruction scrubbing
   always_comb begin
      dec_s        = '0;
      dec_s.rs1    = i_inst[19:15];
      dec_s.rs2    = i_inst[24:20];
      dec_s.rd     = i_inst[11:7];
      illegal_s    = 1'b0;
      wen_s        = 1'b1;

      if (i_inst[1:0] != 2'b11) begin
         illegal_s = 1'b1;
      end else begin
         case (opcode_s)
            OP: begin
               dec_s.opsel = f3_opsel_s;
               dec_s.uns   = f3_uns_s;
               dec_s.arith = (funct3_s == 3'b101) ? i_inst[30] : 1'b0;
               dec_s.sub   = (funct3_s == 3'b000) ? i_inst[30] : 1'b0;
               if (funct7_s == 7'b0000000) begin
                  illegal_s = 1'b0;
               end else if (funct7_s == 7'b0100000) begin
                  illegal_s = (funct3_s != 3'b000) && (funct3_s != 3'b101);
               end else begin
                  illegal_s = 1'b1;
               end
            end
            OP_IMM: begin
               dec_s.opsel  = f3_opsel_s;
               dec_s.uns    = f3_uns_s;
               dec_s.arith  = (funct3_s == 3'b101) ? i_inst[30] : 1'b0;
               dec_s.op2imm = 1'b1;
               dec_s.imm    = imm_i(i_inst);
               // Shift immediates reuse the upper bits as funct7
               if (funct3_s == 3'b001) begin
                  illegal_s = (funct7_s != 7'b0000000);
               end else if (funct3_s == 3'b101) begin
                  illegal_s = (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000);
               end else begin
                  illegal_s = 1'b0;
               end
            end
            LOAD, JALR: begin
               dec_s.op2imm = 1'b1;
               dec_s.imm    = imm_i(i_inst);
            end
            STORE: begin
               dec_s.op2imm = 1'b1;
               dec_s.imm    = imm_s(i_inst);
               wen_s        = 1'b0;
            end
            AUIPC: begin
               dec_s.op1sel = OP1_PC;
               dec_s.op2imm = 1'b1;
               dec_s.imm    = imm_u(i_inst);
            end
            JAL: begin
               dec_s.op1sel = OP1_PC;
               dec_s.op2imm = 1'b1;
               dec_s.imm    = imm_j(i_inst);
            end
            LUI: begin
               dec_s.op1sel = OP1_ZERO;
               dec_s.op2imm = 1'b1;
               dec_s.imm    = imm_u(i_inst);
            end
            BRANCH: begin
               dec_s.imm = imm_b(i_inst);
               wen_s     = 1'b0;
               case (funct3_s)
                  3'b000, 3'b001: begin
                     dec_s.opsel = ALU_ADD;
                     dec_s.sub   = 1'b1;
                  end
                  3'b100, 3'b101: begin
                     dec_s.opsel = ALU_SLT;
                  end
                  3'b110, 3'b111: begin
                     dec_s.opsel = ALU_SLT;
                     dec_s.uns   = 1'b1;
                  end
                  default: illegal_s = 1'b1;
               endcase
            end
            default: illegal_s = 1'b1;
         endcase
      end

      // Illegal encodings carry no ALU control and never write back
      if (illegal_s) begin
         dec_s.opsel   = ALU_ADD;
         dec_s.sub     = 1'b0;
         dec_s.uns     = 1'b0;
         dec_s.arith   = 1'b0;
         dec_s.op1sel  = OP1_RS1;
         dec_s.op2imm  = 1'b0;
         dec_s.rd_wen  = 1'b0;
         dec_s.illegal = 1'b1;
      end else begin
         dec_s.rd_wen  = wen_s && (dec_s.rd != 5'd0);
         dec_s.illegal = 1'b0;
      end
   end

   assign o_bundle = dec_s;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake around a one-entry
// pipeline register holding the decoded bundle.
module decode_stage
   import rv32i_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_inst,
   input  logic        i_flush,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [2:0]  o_opsel,
   output logic        o_sub,
   output logic        o_unsigned,
   output logic        o_arith,
   output logic [1:0]  o_op1sel,
   output logic        o_op2imm,
   output logic [31:0] o_imm,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic [4:0]  o_rd,
   output logic        o_rd_wen,
   output logic        o_illegal
);

   logic [DEC_W-1:0] dec_vec_s;
   dec_bundle_t      dec_s;
   dec_bundle_t      bundle_r;
   logic             valid_r;
   logic             valid_nxt_s;
   logic             accept_s;

   inst_decode u_inst_decode (
      .i_inst   (i_inst),
      .o_bundle (dec_vec_s)
   );

   assign dec_s    = dec_bundle_t'(dec_vec_s);
   assign o_ready  = !valid_r || i_ready;
   assign accept_s = i_valid && o_ready && !i_flush;

   // Next valid: flush wins, then accept, then consume, else hold
   always_comb begin
      valid_nxt_s = valid_r;
      if (i_flush) begin
         valid_nxt_s = 1'b0;
      end else if (accept_s) begin
         valid_nxt_s = 1'b1;
      end else if (i_ready) begin
         valid_nxt_s = 1'b0;
      end else begin
         valid_nxt_s = valid_r;
      end
   end

   // Pipeline register: valid every cycle, payload only on accept
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_r  <= 1'b0;
         bundle_r <= '0;
      end else begin
         valid_r <= valid_nxt_s;
         if (accept_s) begin
            bundle_r <= dec_s;
         end
      end
   end

   assign o_valid    = valid_r;
   assign o_opsel    = bundle_r.opsel;
   assign o_sub      = bundle_r.sub;
   assign o_unsigned = bundle_r.uns;
   assign o_arith    = bundle_r.arith;
   assign o_op1sel   = bundle_r.op1sel;
   assign o_op2imm   = bundle_r.op2imm;
   assign o_imm      = bundle_r.imm;
   assign o_rs1      = bundle_r.rs1;
   assign o_rs2      = bundle_r.rs2;
   assign o_rd       = bundle_r.rd;
   assign o_rd_wen   = bundle_r.rd_wen;
   assign o_illegal  = bundle_r.illegal;

endmodule
